// File: rtl/ap9_fetch_unit_if.sv
// Bus bundle for the AP9 fetch unit.
// Groups the RAM port, the execute-stage access port and the decode-side FIFO head
// so the fetch unit and its environment connect through one port.
//   master : the fetch unit (drives the RAM bus, ex_ack/ex_rdata and the FIFO head).
//   slave  : the RAM + CPU sequencer side.
interface ap9_fetch_unit_if #(
  parameter int unsigned DEPTH = 4
);
  // RAM port
  logic [15:0]              bus_RAM_ADDRESS;
  logic [15:0]              bus_RAM_DATA_OUT;
  logic                     wire_RW;
  logic [15:0]              bus_RAM_DATA_IN;
  // Execute-stage data access
  logic                     ex_req;
  logic                     ex_we;
  logic [15:0]              ex_addr;
  logic [15:0]              ex_wdata;
  logic                     ex_ack;
  logic [15:0]              ex_rdata;
  // Redirect
  logic                     flush;
  logic [15:0]              flush_pc;
  // Instruction stream to decode
  logic                     ir_valid;
  logic                     ir_ready;
  logic [15:0]              ir_word;
  logic [15:0]              ir_pc;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output bus_RAM_ADDRESS, wire_RW, bus_RAM_DATA_IN,
    output ex_ack, ex_rdata,
    output ir_valid, ir_word, ir_pc, fifo_count,
    input  bus_RAM_DATA_OUT,
    input  ex_req, ex_we, ex_addr, ex_wdata,
    input  flush, flush_pc,
    input  ir_ready
  );

  modport slave (
    input  bus_RAM_ADDRESS, wire_RW, bus_RAM_DATA_IN,
    input  ex_ack, ex_rdata,
    input  ir_valid, ir_word, ir_pc, fifo_count,
    output bus_RAM_DATA_OUT,
    output ex_req, ex_we, ex_addr, ex_wdata,
    output flush, flush_pc,
    output ir_ready
  );
endinterface

// File: rtl/ap9_fetch_unit.sv
// AP9 instruction prefetch unit and RAM-port arbiter.
// Streams instruction words from the single-port RAM into a DEPTH-entry FIFO tagged with
// their fetch address, and gives execute-stage data accesses priority on the shared bus.
// Every RAM access is two cycles: an issue edge (address/RW/data registered) and a
// capture edge (read data sampled).
// Ports:
//   wire_clock   : system clock, rising edge.
//   wire_reset_n : asynchronous active-low reset.
//   fu           : ap9_fetch_unit_if master (RAM bus, ex access port, FIFO head, flush).
// DEPTH must be a power of two >= 2 so the FIFO pointers wrap by natural overflow.
module ap9_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic               wire_clock,
  input logic               wire_reset_n,
  ap9_fetch_unit_if.master  fu
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IF   = 2'd1;
  localparam logic [1:0] S_EX   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;

  logic [15:0]   word_q [DEPTH];
  logic [15:0]   pc_q   [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          ir_valid;
  logic          push;
  logic          pop;

  assign ir_valid = (count_q != '0);
  // A flush empties the FIFO, so it overrides any pop of the old head.
  assign pop      = ir_valid & fu.ir_ready & ~fu.flush;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // ex_req is still high during the ack cycle; ignoring it then avoids a reissue.
        if (fu.ex_req && !ack_q) begin
          addr_d  = fu.ex_addr;
          rw_d    = fu.ex_we;
          wdata_d = fu.ex_wdata;
          state_d = S_EX;
        end else if (!fu.flush && (count_q < CW'(DEPTH))) begin
          addr_d  = fetch_pc_q;
          rw_d    = 1'b0;
          state_d = S_IF;
        end else begin
          rw_d    = 1'b0;
        end
      end
      S_IF: begin
        // A flush on the capture edge drops the word and leaves fetch_pc to the redirect.
        if (!fu.flush) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      S_EX: begin
        if (!rw_q) rdata_d = fu.bus_RAM_DATA_OUT;
        ack_d   = 1'b1;
        rw_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        rw_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (fu.flush) fetch_pc_d = fu.flush_pc;
  end

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'h0000;
      rw_q       <= 1'b0;
      wdata_q    <= 16'h0000;
      rdata_q    <= 16'h0000;
      ack_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        word_q[i] <= 16'h0000;
        pc_q[i]   <= 16'h0000;
      end
    end else if (fu.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        word_q[wr_ptr_q] <= fu.bus_RAM_DATA_OUT;
        pc_q[wr_ptr_q]   <= addr_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign fu.bus_RAM_ADDRESS = addr_q;
  assign fu.wire_RW         = rw_q;
  assign fu.bus_RAM_DATA_IN = wdata_q;
  assign fu.ex_ack          = ack_q;
  assign fu.ex_rdata        = rdata_q;
  assign fu.ir_valid        = ir_valid;
  assign fu.ir_word         = word_q[rd_ptr_q];
  assign fu.ir_pc           = pc_q[rd_ptr_q];
  assign fu.fifo_count      = count_q;

  // The requester must hold its access stable and asserted until it is acknowledged.
  ex_req_held: assert property (@(posedge wire_clock) disable iff (!wire_reset_n)
      (state_q == S_EX) |-> (fu.ex_req && (fu.ex_addr == addr_q) && (fu.ex_we == rw_q) &&
                             (!rw_q || (fu.ex_wdata == wdata_q))));

endmodule

// File: tb/tb_ap9_fetch_unit.sv
// Self-checking bench for ap9_fetch_unit: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference (memory image, expected
// instruction PC stream, execute access results and latency bound).
module tb_ap9_fetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic clk = 1'b0;
  logic rst_n;

  logic          ex_req, ex_we, flush, ir_ready;
  logic [15:0]   ex_addr, ex_wdata, flush_pc;
  logic [15:0]   ram_addr, ram_din, ex_rdata, ir_word, ir_pc;
  logic          ram_rw, ex_ack, ir_valid;
  logic [CW-1:0] fifo_count;

  logic [15:0] dev_ram [65536];  // the RAM device on the bus
  logic [15:0] ref_mem [65536];  // reference memory image
  logic [15:0] exp_pc;           // next PC decode should receive
  logic [15:0] pops[$];          // PCs popped, in order

  int n_checks = 0;
  int n_errors = 0;

  ap9_fetch_unit_if #(.DEPTH(DEPTH)) u_if ();

  assign u_if.ex_req           = ex_req;
  assign u_if.ex_we            = ex_we;
  assign u_if.ex_addr          = ex_addr;
  assign u_if.ex_wdata         = ex_wdata;
  assign u_if.flush            = flush;
  assign u_if.flush_pc         = flush_pc;
  assign u_if.ir_ready         = ir_ready;
  assign u_if.bus_RAM_DATA_OUT = dev_ram[u_if.bus_RAM_ADDRESS];
  assign ram_addr   = u_if.bus_RAM_ADDRESS;
  assign ram_rw     = u_if.wire_RW;
  assign ram_din    = u_if.bus_RAM_DATA_IN;
  assign ex_ack     = u_if.ex_ack;
  assign ex_rdata   = u_if.ex_rdata;
  assign ir_valid   = u_if.ir_valid;
  assign ir_word    = u_if.ir_word;
  assign ir_pc      = u_if.ir_pc;
  assign fifo_count = u_if.fifo_count;

  ap9_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_dut (
    .wire_clock   (clk),
    .wire_reset_n (rst_n),
    .fu           (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample pre-edge inputs/outputs, advance past the edge, update the
  // RAM device and the reference model, and check the instruction stream.
  task automatic step();
    logic        pop, fl, wr;
    logic [15:0] pc_s, word_s, fpc, wa, wd;
    pop    = ir_valid && ir_ready && !flush && rst_n;
    fl     = flush && rst_n;
    fpc    = flush_pc;
    pc_s   = ir_pc;
    word_s = ir_word;
    wr     = ram_rw;
    wa     = ram_addr;
    wd     = ram_din;
    @(posedge clk);
    #1;
    if (wr) dev_ram[wa] = wd;
    if (!rst_n) begin
      exp_pc = RESET_PC;
    end else begin
      if (pop) begin
        check_eq("pop_pc", pc_s, exp_pc);
        check_eq("pop_word", word_s, ref_mem[pc_s]);
        pops.push_back(pc_s);
        exp_pc = exp_pc + 16'd1;
      end
      if (fl) begin
        exp_pc = fpc;
        check_eq("flush_count", fifo_count, 0);
        check_eq("flush_valid", ir_valid, 0);
      end
      check_eq("count_max", fifo_count <= DEPTH, 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_addr"}, ram_addr, 0);
    check_eq({tag, "_rw"}, ram_rw, 0);
    check_eq({tag, "_din"}, ram_din, 0);
    check_eq({tag, "_ack"}, ex_ack, 0);
    check_eq({tag, "_rdata"}, ex_rdata, 0);
    check_eq({tag, "_valid"}, ir_valid, 0);
    check_eq({tag, "_count"}, fifo_count, 0);
    check_eq({tag, "_word"}, ir_word, 0);
    check_eq({tag, "_pc"}, ir_pc, 0);
  endtask

  // Execute access: issue must appear on the bus in the cycle before the ack, the ack
  // must come within 3 edges (one fetch capture + issue + capture) and pulse once.
  task automatic ex_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                           input bit do_flush, input logic [15:0] fpc);
    int          n, rw_cycles;
    bit          acked;
    logic [15:0] exp_rd, last_addr, last_din;
    logic        last_rw;
    exp_rd = 16'h0000;
    if (we) ref_mem[a] = d;
    else    exp_rd = ref_mem[a];
    ex_req = 1'b1; ex_we = we; ex_addr = a; ex_wdata = d;
    if (do_flush) begin
      flush    = 1'b1;
      flush_pc = fpc;
    end
    last_addr = ram_addr; last_rw = ram_rw; last_din = ram_din;
    n = 0; rw_cycles = 0; acked = 1'b0;
    while (!acked && n < 4) begin
      step();
      flush = 1'b0;
      n++;
      if (ram_rw) rw_cycles++;
      if (ex_ack) acked = 1'b1;
      else begin
        last_addr = ram_addr; last_rw = ram_rw; last_din = ram_din;
      end
    end
    check_eq("ex_acked", acked, 1);
    check_eq("ex_latency_le3", n <= 3, 1);
    check_eq("ex_issue_addr", last_addr, a);
    check_eq("ex_issue_rw", last_rw, we);
    if (we) check_eq("ex_issue_wdata", last_din, d);
    check_eq("ex_rw_cycles", rw_cycles, we ? 1 : 0);
    if (!we) check_eq("ex_rdata", ex_rdata, exp_rd);
    // Keep ex_req high through the ack cycle: it must not be taken as a new request.
    step();
    ex_req = 1'b0;
    check_eq("ex_ack_pulse", ex_ack, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("ex_no_reissue", ex_ack, 0);
    end
  endtask

  task automatic flush_to(input logic [15:0] fpc);
    flush = 1'b1; flush_pc = fpc;
    step();
    flush = 1'b0;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i * 40503) ^ 16'h5A3C;
    ref_mem[0] = 16'hC000; ref_mem[1] = 16'h0010; ref_mem[2] = 16'hE000;
    ref_mem[3] = 16'h1234; ref_mem[4] = 16'hF000; ref_mem[5] = 16'h0000;
    ref_mem[16'h0010] = 16'hBEEF;
    for (int i = 0; i < 65536; i++) dev_ram[i] = ref_mem[i];
    exp_pc = RESET_PC;
    rst_n = 1'b0;
    ex_req = 1'b0; ex_we = 1'b0; ex_addr = '0; ex_wdata = '0;
    flush = 1'b0; flush_pc = '0; ir_ready = 1'b0;

    // Reset state
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Fill: addresses 0..3 fetched, then fetching stops
    for (int i = 0; i < 8; i++) step();
    check_eq("fill_count", fifo_count, DEPTH);
    check_eq("fill_word", ir_word, 16'hC000);
    check_eq("fill_pc", ir_pc, 16'h0000);
    for (int i = 0; i < 4; i++) step();
    check_eq("full_last_addr", ram_addr, 16'h0003);
    check_eq("full_count", fifo_count, DEPTH);

    // Drain with ir_ready for 6 cycles: words 0..5 in order
    base = pops.size();
    ir_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    ir_ready = 1'b0;
    check_eq("drain_pops", pops.size() - base, 6);
    check_eq("drain_last_pc", pops[$], 16'h0005);

    // Read while a fetch is in flight, then write and read back
    ex_access(1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000);
    ex_access(1'b1, 16'h0020, 16'h5A5A, 1'b0, 16'h0000);
    check_eq("ram_written", dev_ram[16'h0020], 16'h5A5A);
    ex_access(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000);

    // Flush during an S_IF capture with two entries queued
    flush_to(16'h0200);
    for (int i = 0; i < 5; i++) step();
    check_eq("preflush_count", fifo_count, 2);
    check_eq("preflush_addr", ram_addr, 16'h0202);
    flush_to(16'h0100);
    step();
    check_eq("redirect_addr", ram_addr, 16'h0100);
    step();
    check_eq("redirect_count", fifo_count, 1);
    check_eq("redirect_pc", ir_pc, 16'h0100);
    check_eq("redirect_word", ir_word, ref_mem[16'h0100]);

    // Fetch PC wrap
    flush_to(16'hFFFE);
    pops.delete();
    ir_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    ir_ready = 1'b0;
    check_eq("wrap_pops", pops.size() >= 4, 1);
    if (pops.size() >= 4) begin
      check_eq("wrap_pc0", pops[0], 16'hFFFE);
      check_eq("wrap_pc1", pops[1], 16'hFFFF);
      check_eq("wrap_pc2", pops[2], 16'h0000);
      check_eq("wrap_pc3", pops[3], 16'h0001);
    end

    // Reset in the middle of an execute access
    flush_to(16'h0300);
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 16'h4000;
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    ex_req = 1'b0;
    step();
    check_eq("midrst_ack", ex_ack, 0);
    rst_n = 1'b1;
    step();
    check_eq("restart_addr", ram_addr, RESET_PC);
    check_eq("restart_rw", ram_rw, 0);
    step();
    check_eq("restart_count", fifo_count, 1);
    check_eq("restart_pc", ir_pc, RESET_PC);
    check_eq("restart_word", ir_word, ref_mem[RESET_PC]);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      ir_ready = 1'($urandom_range(0, 1));
      if (r < 10) begin
        logic        we;
        logic [15:0] a;
        we = 1'($urandom_range(0, 1));
        if (we || $urandom_range(0, 1) == 1) a = 16'h4000 + 16'($urandom_range(0, 255));
        else                                  a = 16'($urandom_range(0, 16'h0FFF));
        ex_access(we, a, 16'($urandom), $urandom_range(0, 7) == 0,
                  16'($urandom_range(0, 16'h0FFF)));
      end else if (r < 15) begin
        flush_to(16'($urandom_range(0, 16'h0FFF)));
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
